// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer between the decode-stage memory
// controls and a valid/ready data-memory bus. One access is captured at a
// time, issued as a word-aligned request with a byte-lane mask, and (for
// loads) the returned word is lane-selected and sign/zero-extended.
//
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into an immediate err+done with no bus traffic. Without it the
// offending low address bits are simply masked to natural alignment.
module lsu_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              MemRd,
   input  logic              MemWr,
   input  logic [2:0]        MemOp,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_wen,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   output logic [3:0]        req_wmask,
   input  logic              resp_valid,
   input  logic [DATA_W-1:0] resp_data
);

   // Access size classes derived from MemOp.
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // Size class of a MemOp; the reserved encodings 011/110/111 behave as word.
   function automatic logic [1:0] op_size(input logic [2:0] op);
      logic [1:0] sz;
      case (op)
         3'b000, 3'b100: sz = SZ_BYTE;
         3'b001, 3'b101: sz = SZ_HALF;
         default:        sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   // Only lbu/lhu are zero-extended.
   function automatic logic op_unsigned(input logic [2:0] op);
      return (op == 3'b100) || (op == 3'b101);
   endfunction

   // Byte-enable mask for a store of the given size at byte offset off.
   // Halfwords use lane {off[1],0}, which also realigns an odd half offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = 4'b0011 << {off[1], 1'b0};
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Right-aligned store data shifted onto its byte lanes; unused lanes are zero.
   function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                                   input logic [DATA_W-1:0] wd);
      logic [DATA_W-1:0] d;
      case (size)
         SZ_BYTE: d = {{(DATA_W-8){1'b0}}, wd[7:0]} << {off, 3'b000};
         SZ_HALF: d = {{(DATA_W-16){1'b0}}, wd[15:0]} << {off[1], 4'b0000};
         default: d = wd;
      endcase
      return d;
   endfunction

   // Select the addressed byte/half of a read word and extend it.
   function automatic logic [DATA_W-1:0] load_extend(input logic [1:0] size, input logic uns,
                                                     input logic [1:0] off,
                                                     input logic [DATA_W-1:0] word);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] res;
      sh  = {DATA_W{1'b0}};
      res = word;
      case (size)
         SZ_BYTE: begin
            sh  = word >> {off, 3'b000};
            res = {{(DATA_W-8){sh[7] & ~uns}}, sh[7:0]};
         end
         SZ_HALF: begin
            sh  = word >> {off[1], 4'b0000};
            res = {{(DATA_W-16){sh[15] & ~uns}}, sh[15:0]};
         end
         default: res = word;
      endcase
      return res;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   // Half needs an even address, word needs a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_HALF: mis = off[0];
         SZ_WORD: mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction
`endif

   state_t            state_r;
   state_t            next_state_s;
   logic              stall_s;
   logic [2:0]        op_r;
   logic [1:0]        off_r;
   logic              wen_r;
   logic [ADDR_W-1:0] req_addr_r;
   logic [DATA_W-1:0] req_wdata_r;
   logic [3:0]        req_wmask_r;
   logic [DATA_W-1:0] rdata_r;

   logic              accept_s;
   logic              is_write_s;
   logic [1:0]        in_size_s;
   logic              trap_s;

   // A read wins when MemRd and MemWr are both set.
   assign accept_s   = in_valid & (MemRd | MemWr);
   assign is_write_s = MemWr & ~MemRd;
   assign in_size_s  = op_size(MemOp);

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_r;
   assign trap_s = is_misaligned(in_size_s, addr[1:0]);
   assign err    = err_r;

   // err pulses during the DONE cycle that follows a trapped accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else begin
         err_r <= (state_r == ST_IDLE) & accept_s & trap_s;
      end
   end
`else
   assign trap_s = 1'b0;
   assign err    = 1'b0;
`endif

   // State register; async reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode and stall; stall in IDLE reacts combinationally to a new access.
   always_comb begin
      next_state_s = state_r;
      stall_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               stall_s = 1'b1;
               if (trap_s) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_REQ;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            stall_s = 1'b1;
            if (req_ready) begin
               next_state_s = ST_WAIT;
            end else begin
               next_state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            stall_s = 1'b1;
            if (resp_valid) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Capture the request at accept and the extended load result on the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r        <= 3'b000;
         off_r       <= 2'b00;
         wen_r       <= 1'b0;
         req_addr_r  <= {ADDR_W{1'b0}};
         req_wdata_r <= {DATA_W{1'b0}};
         req_wmask_r <= 4'b0000;
         rdata_r     <= {DATA_W{1'b0}};
      end else begin
         if ((state_r == ST_IDLE) && accept_s) begin
            op_r       <= MemOp;
            off_r      <= addr[1:0];
            wen_r      <= is_write_s & ~trap_s;
            req_addr_r <= {addr[ADDR_W-1:2], 2'b00};
            if (is_write_s && !trap_s) begin
               req_wmask_r <= lane_mask(in_size_s, addr[1:0]);
               req_wdata_r <= lane_data(in_size_s, addr[1:0], wdata);
            end else begin
               req_wmask_r <= 4'b0000;
               req_wdata_r <= {DATA_W{1'b0}};
            end
            if (trap_s) begin
               rdata_r <= {DATA_W{1'b0}};
            end
         end else if ((state_r == ST_WAIT) && resp_valid && !wen_r) begin
            rdata_r <= load_extend(op_size(op_r), op_unsigned(op_r), off_r, resp_data);
         end
      end
   end

   assign stall     = stall_s;
   assign done      = (state_r == ST_DONE);
   assign req_valid = (state_r == ST_REQ);
   assign req_wen   = wen_r;
   assign req_addr  = req_addr_r;
   assign req_wdata = req_wdata_r;
   assign req_wmask = req_wmask_r;
   assign rdata     = rdata_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed accesses plus randomized
// loads/stores with random bus latencies, checked against a byte-level model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, MemRd, MemWr;
   logic [2:0]  MemOp;
   logic [31:0] addr, wdata;
   logic        stall, done, err;
   logic [31:0] rdata;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid;
   logic [31:0] resp_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .MemRd(MemRd), .MemWr(MemWr),
      .MemOp(MemOp), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .rdata(rdata), .err(err), .req_valid(req_valid), .req_ready(req_ready),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wmask(req_wmask), .resp_valid(resp_valid), .resp_data(resp_data)
   );

   // Reference model: access width in bytes.
   function automatic int acc_bytes(input logic [2:0] op);
      if (op == 3'd0 || op == 3'd4) return 1;
      if (op == 3'd1 || op == 3'd5) return 2;
      return 4;
   endfunction

   // Reference model: lowest byte lane touched by the access.
   function automatic int lane_of(input int nb, input logic [31:0] a);
      int off;
      off = int'(a % 32'd4);
      if (nb == 1) return off;
      if (nb == 2) return (off / 2) * 2;
      return 0;
   endfunction

   function automatic bit misaligned_m(input int nb, input logic [31:0] a);
      return (nb == 2 && (a % 32'd2) != 32'd0) || (nb == 4 && (a % 32'd4) != 32'd0);
   endfunction

   // Runs one complete access and checks every phase against the model.
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rw,
                             input int rdy_dly, input int rsp_dly,
                             output logic [31:0] got);
      int nb, lane;
      logic is_wr, uns, trap;
      logic [3:0] e_mask;
      logic [31:0] e_addr, e_wdata, e_bytes, e_rdata, v;
      nb    = acc_bytes(op);
      lane  = lane_of(nb, a);
      is_wr = wr && !rd;
      uns   = (op == 3'd4 || op == 3'd5);
      trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap  = misaligned_m(nb, a);
`endif
      e_addr = a - (a % 32'd4);
      e_mask = 4'h0;
      if (is_wr) e_mask = (nb == 4) ? 4'hF : (nb == 2) ? (4'h3 << lane) : (4'h1 << lane);
      if (nb == 4) e_wdata = wd;
      else if (nb == 2) e_wdata = (wd % 32'd65536) << (8 * lane);
      else e_wdata = (wd % 32'd256) << (8 * lane);
      e_bytes = 32'h0;
      for (int i = 0; i < 4; i++) if (e_mask[i]) e_bytes = e_bytes | (32'hFF << (8 * i));
      v = rw >> (8 * lane);
      if (nb == 1) begin
         v = v % 32'd256;
         if (!uns && v >= 32'd128) v = v - 32'd256;
      end else if (nb == 2) begin
         v = v % 32'd65536;
         if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end
      e_rdata = trap ? 32'h0 : v;
      got = 32'h0;

      @(negedge clk);
      in_valid = 1'b1; MemRd = rd; MemWr = wr; MemOp = op; addr = a; wdata = wd;
      req_ready = 1'b0; resp_valid = 1'b0;
      #1;
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL %s accept_stall: got %b exp 1", tag, stall); end
      n_tests++;
      if (req_valid !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL %s accept_idle: req_valid %b done %b exp 0 0", tag, req_valid, done);
      end
      @(negedge clk);
      in_valid = 1'(($urandom % 2)); addr = $urandom; wdata = $urandom; MemOp = 3'($urandom % 8);
      if (trap) begin
         #1;
         n_tests++;
         if (done !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || req_valid !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s trap: done %b err %b rdata %h req_valid %b stall %b exp 1 1 0 0 0",
                     tag, done, err, rdata, req_valid, stall);
         end
         got = rdata;
      end else begin
         for (int k = 0; k <= rdy_dly; k++) begin
            req_ready = (k == rdy_dly); resp_valid = 1'(($urandom % 2)); resp_data = $urandom;
            #1;
            n_tests++;
            if (req_valid !== 1'b1 || stall !== 1'b1 || done !== 1'b0) begin
               n_fail++; $display("FAIL %s req_phase: req_valid %b stall %b done %b exp 1 1 0", tag, req_valid, stall, done);
            end
            n_tests++;
            if (req_addr !== e_addr || req_wen !== is_wr || req_wmask !== e_mask) begin
               n_fail++;
               $display("FAIL %s req_fields: addr %h wen %b mask %b exp %h %b %b", tag, req_addr, req_wen, req_wmask, e_addr, is_wr, e_mask);
            end
            n_tests++;
            if ((req_wdata & e_bytes) !== (e_wdata & e_bytes)) begin
               n_fail++; $display("FAIL %s req_wdata: got %h exp %h (lanes %h)", tag, req_wdata, e_wdata, e_bytes);
            end
            @(negedge clk);
         end
         req_ready = 1'b0;
         for (int k = 0; k <= rsp_dly; k++) begin
            resp_valid = (k == rsp_dly); resp_data = (k == rsp_dly) ? rw : $urandom;
            req_ready = 1'(($urandom % 2));
            #1;
            n_tests++;
            if (req_valid !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
               n_fail++; $display("FAIL %s wait_phase: req_valid %b stall %b done %b exp 0 1 0", tag, req_valid, stall, done);
            end
            @(negedge clk);
         end
         resp_valid = 1'(($urandom % 2)); resp_data = $urandom; req_ready = 1'b0;
         in_valid = 1'b1; MemRd = 1'b1; MemWr = 1'b0;
         #1;
         n_tests++;
         if (done !== 1'b1 || err !== 1'b0 || stall !== 1'b0 || req_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s done_cycle: done %b err %b stall %b req_valid %b exp 1 0 0 0", tag, done, err, stall, req_valid);
         end
         if (!is_wr) begin
            n_tests++;
            if (rdata !== e_rdata) begin n_fail++; $display("FAIL %s rdata: got %h exp %h", tag, rdata, e_rdata); end
         end
         got = rdata;
      end
      @(negedge clk);
      in_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; resp_valid = 1'b0; req_ready = 1'b0;
      #1;
      n_tests++;
      if (done !== 1'b0 || err !== 1'b0 || req_valid !== 1'b0 || stall !== 1'b0) begin
         n_fail++; $display("FAIL %s after_done: done %b err %b req_valid %b stall %b exp 0 0 0 0", tag, done, err, req_valid, stall);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOp = 3'd0;
      addr = 32'h0; wdata = 32'h0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
      @(negedge clk); @(negedge clk);
      #1;
      n_tests++;
      if (stall !== 1'b0 || done !== 1'b0 || err !== 1'b0 || req_valid !== 1'b0 || req_wen !== 1'b0 ||
          req_addr !== 32'h0 || req_wdata !== 32'h0 || rdata !== 32'h0 || req_wmask !== 4'h0) begin
         n_fail++;
         $display("FAIL reset: stall %b done %b err %b rv %b wen %b addr %h wd %h rd %h mask %b exp all 0",
                  stall, done, err, req_valid, req_wen, req_addr, req_wdata, rdata, req_wmask);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_noise;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            in_valid = 1'b1; MemRd = 1'b0; MemWr = 1'b0;
         end else begin
            in_valid = 1'b0; MemRd = 1'(($urandom % 2)); MemWr = 1'(($urandom % 2));
         end
         resp_valid = 1'(($urandom % 2)); req_ready = 1'(($urandom % 2));
         #1;
         n_tests++;
         if (stall !== 1'b0 || req_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_noise: stall %b req_valid %b done %b exp 0 0 0", stall, req_valid, done);
         end
      end
      @(negedge clk);
      in_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; resp_valid = 1'b0; req_ready = 1'b0;
   endtask

   task automatic test_directed;
      logic [31:0] got;
      run_access("sw", 1'b0, 1'b1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0, 0, 0, got);
      run_access("sb", 1'b0, 1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0, 0, 0, got);
      run_access("lb", 1'b1, 1'b0, 3'b000, 32'h80000002, 32'h0, 32'h12F03456, 0, 0, got);
      n_tests++;
      if (got !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_value: got %h exp FFFFFFF0", got); end
      run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h80000002, 32'h0, 32'h12F03456, 0, 0, got);
      n_tests++;
      if (got !== 32'h000000F0) begin n_fail++; $display("FAIL lbu_value: got %h exp 000000F0", got); end
      run_access("lh", 1'b1, 1'b0, 3'b001, 32'h80000002, 32'h0, 32'h8001ABCD, 3, 1, got);
      n_tests++;
      if (got !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_value: got %h exp FFFF8001", got); end
      run_access("rdwr", 1'b1, 1'b1, 3'b010, 32'h80000008, 32'h55555555, 32'h13579BDF, 1, 2, got);
      n_tests++;
      if (got !== 32'h13579BDF) begin n_fail++; $display("FAIL rdwr_value: got %h exp 13579BDF", got); end
   endtask

   task automatic test_misalign;
      logic [31:0] got;
`ifdef LSU_MISALIGN_TRAP_EN
      run_access("lw_trap", 1'b1, 1'b0, 3'b010, 32'h80000002, 32'h0, 32'hCAFEF00D, 0, 0, got);
      n_tests++;
      if (got !== 32'h0) begin n_fail++; $display("FAIL lw_trap_value: got %h exp 0", got); end
      run_access("sh_trap", 1'b0, 1'b1, 3'b001, 32'h80000001, 32'h1234, 32'h0, 0, 0, got);
`else
      run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h80000002, 32'h0, 32'hCAFEF00D, 0, 0, got);
      n_tests++;
      if (got !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lw_mis_value: got %h exp CAFEF00D", got); end
      run_access("lh_mis", 1'b1, 1'b0, 3'b001, 32'h80000003, 32'h0, 32'h8001ABCD, 0, 0, got);
      n_tests++;
      if (got !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_mis_value: got %h exp FFFF8001", got); end
`endif
   endtask

   task automatic test_random;
      logic [31:0] got;
      logic rd, wr;
      for (int i = 0; i < 40; i++) begin
         rd = 1'(($urandom % 2));
         wr = rd ? 1'(($urandom % 4) == 0) : 1'b1;
         run_access($sformatf("rnd%0d", i), rd, wr, 3'($urandom % 8), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      in_valid = 1'b1; MemRd = 1'b1; MemWr = 1'b0; MemOp = 3'b010; addr = 32'h80000010;
      @(negedge clk);
      in_valid = 1'b0; MemRd = 1'b0; req_ready = 1'b0;
      #1;
      n_tests++;
      if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre: req_valid %b exp 1", req_valid); end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (req_valid !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL rst_in_req: req_valid %b stall %b done %b exp 0 0 0", req_valid, stall, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; MemRd = 1'b1; MemOp = 3'b000; addr = 32'h80000021;
      @(negedge clk);
      in_valid = 1'b0; MemRd = 1'b0; req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      #1;
      n_tests++;
      if (req_valid !== 1'b0 || stall !== 1'b1) begin
         n_fail++; $display("FAIL rst_wait_pre: req_valid %b stall %b exp 0 1", req_valid, stall);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (req_valid !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL rst_in_wait: req_valid %b stall %b done %b exp 0 0 0", req_valid, stall, done);
      end
      @(negedge clk);
      rst_n = 1'b1; resp_valid = 1'b1; resp_data = 32'h000000FF;
      @(negedge clk);
      resp_valid = 1'b0;
      #1;
      n_tests++;
      if (done !== 1'b0 || stall !== 1'b0 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_late_resp: done %b stall %b req_valid %b exp 0 0 0", done, stall, req_valid);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (done !== 1'b0 || req_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_late_resp2: done %b req_valid %b exp 0 0", done, req_valid);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle_noise();
      test_directed();
      test_misalign();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
